dmem_store_buffer: RTL and testbench

- Posted-write store buffer between the RVI32 core data port and the data memory (dmem).
- Core stores enter a FIFO and drain to dmem in the background.
- Core loads are served either by forwarding from the youngest matching buffered store or by a dmem read.
- Every accepted load returns data exactly one cycle later.

---
 rtl/dmem_store_buffer.sv | 145 ++++++++++++++
 tb/tb_dmem_store_buffer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the core data port and dmem.
// Stores queue in a small FIFO and drain in the background; loads are
// forwarded from the youngest matching entry or read from dmem, and every
// accepted load returns data exactly one cycle later.
module dmem_store_buffer #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         c_req,
  input  logic                         c_we,
  input  logic [ADDR_WIDTH-1:0]        c_addr,
  input  logic [DATA_WIDTH-1:0]        c_wdata,
  output logic                         c_ready,
  output logic                         c_rvalid,
  output logic [DATA_WIDTH-1:0]        c_rdata,
  output logic [ADDR_WIDTH-1:0]        m_addr,
  output logic [DATA_WIDTH-1:0]        m_wdata,
  output logic                         m_we,
  input  logic                         m_ready,
  input  logic [DATA_WIDTH-1:0]        m_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  // Buffer storage; entries past count are don't-care and never reset.
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [STV_W-1:0]      starve_q, starve_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rsrc_mem_q, rsrc_mem_d;
  logic [DATA_WIDTH-1:0] fwd_q, fwd_d;

  logic                  hit_c;
  logic [DATA_WIDTH-1:0] hit_data_c;
  logic [PTR_W-1:0]      idx_c;
  logic                  load_c;
  logic                  stall_c;
  logic                  store_acc_c;
  logic                  hit_acc_c;
  logic                  miss_acc_c;
  logic                  drain_c;

  // Search oldest to youngest so the youngest matching entry wins.
  always_comb begin
    hit_c      = 1'b0;
    hit_data_c = '0;
    idx_c      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx_c = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[idx_c] == c_addr)) begin
        hit_c      = 1'b1;
        hit_data_c = data_q[idx_c];
      end
    end
  end

  // Acceptance and dmem port arbitration: an accepted load miss owns the port.
  always_comb begin
    load_c      = c_req & ~c_we;
    stall_c     = load_c & ~hit_c & (starve_q == STV_W'(STARVE_LIMIT)) & (count_q != '0);
    store_acc_c = ~RESET & c_req & c_we & (count_q < CNT_W'(DEPTH));
    hit_acc_c   = ~RESET & load_c & hit_c;
    miss_acc_c  = ~RESET & load_c & ~hit_c & ~stall_c;
    drain_c     = ~RESET & (count_q != '0) & m_ready & ~miss_acc_c;
    c_ready     = store_acc_c | hit_acc_c | miss_acc_c;
    m_we        = drain_c;
    m_addr      = drain_c ? addr_q[head_q] : c_addr;
    m_wdata     = drain_c ? data_q[head_q] : '0;
  end

  // Next-state for pointers, occupancy, starvation and load response.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    starve_d   = starve_q;
    rvalid_d   = hit_acc_c | miss_acc_c;
    rsrc_mem_d = miss_acc_c;
    fwd_d      = fwd_q;
    if (store_acc_c) tail_d = tail_q + PTR_W'(1);
    if (drain_c)     head_d = head_q + PTR_W'(1);
    case ({store_acc_c, drain_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (drain_c || (count_q == '0)) begin
      starve_d = '0;
    end else if (miss_acc_c && m_ready && (starve_q < STV_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + STV_W'(1);
    end
    if (hit_acc_c) fwd_d = hit_data_c;
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      rvalid_q   <= 1'b0;
      rsrc_mem_q <= 1'b1;
      fwd_q      <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rvalid_q   <= rvalid_d;
      rsrc_mem_q <= rsrc_mem_d;
      fwd_q      <= fwd_d;
    end
  end

  // Enqueue an accepted store at the tail.
  always_ff @(posedge CLK) begin
    if (store_acc_c) begin
      addr_q[tail_q] <= c_addr;
      data_q[tail_q] <= c_wdata;
    end
  end

  // Load data: dmem pass-through or registered forward, zero when idle.
  always_comb begin
    c_rvalid = rvalid_q;
    c_rdata  = '0;
    if (rvalid_q) c_rdata = rsrc_mem_q ? m_rdata : fwd_q;
    count    = count_q;
    empty    = (count_q == '0);
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: dmem model, architectural memory scoreboard
// for load data, and an in-order queue for expected drain writes.
module tb_dmem_store_buffer;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SL    = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          CLK = 1'b0;
  logic          RESET;
  logic          c_req, c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_ready, c_rvalid;
  logic [DW-1:0] c_rdata;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_we;
  logic          m_ready;
  logic [DW-1:0] m_rdata;
  logic [CW-1:0] count;
  logic          empty;

  dmem_store_buffer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .STARVE_LIMIT(SL)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ready(c_ready), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .count(count), .empty(empty)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // dmem: synchronous write, read data valid the cycle after the address.
  logic [DW-1:0] mem  [1 << AW];
  logic [DW-1:0] arch [1 << AW];
  always @(posedge CLK) begin
    if (m_we) mem[m_addr] <= m_wdata;
    m_rdata <= mem[m_addr];
  end

  logic [AW+DW-1:0] wq [$];
  logic [DW-1:0]    rq [$];
  logic [AW+DW-1:0] wexp;
  int               we_pulses = 0;
  int               max_cnt   = 0;
  bit               armed     = 1'b0;
  bit               rand_mr   = 1'b0;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (RESET) begin
      wq.delete();
      rq.delete();
      for (int a = 0; a < (1 << AW); a++) arch[a] = mem[a];
    end else if (armed) begin
      if (c_rvalid) begin
        check_eq("rvalid_pending", 64'(rq.size() > 0), 64'd1);
        if (rq.size() > 0) check_eq("load_data", 64'(c_rdata), 64'(rq.pop_front()));
      end else begin
        check_eq("rdata_idle_zero", 64'(c_rdata), 64'd0);
      end
      if (m_we) begin
        we_pulses++;
        check_eq("drain_pending", 64'(wq.size() > 0), 64'd1);
        if (wq.size() > 0) begin
          wexp = wq.pop_front();
          check_eq("drain_addr", 64'(m_addr), 64'(wexp[AW+DW-1:DW]));
          check_eq("drain_data", 64'(m_wdata), 64'(wexp[DW-1:0]));
        end
      end
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (c_req && c_ready) begin
        if (c_we) begin
          wq.push_back({c_addr, c_wdata});
          arch[c_addr] = c_wdata;
        end else begin
          rq.push_back(arch[c_addr]);
        end
      end
    end
  end

  // Random dmem back-pressure for the mixed-traffic phase.
  always @(posedge CLK) begin
    if (rand_mr) begin
      #1;
      m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc = 1'b0;
    c_req = 1'b1; c_we = we; c_addr = a; c_wdata = d;
    for (int k = 0; k < 100 && !acc; k++) begin
      #2;
      acc = c_ready;
      tick();
    end
    check_eq("req_accept", 64'(acc), 64'd1);
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 100 && !empty; k++) tick();
    check_eq("wait_empty", 64'(empty), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int p0;

  initial begin
    RESET = 1'b1; c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0; m_ready = 1'b1;
    for (int a = 0; a < (1 << AW); a++) begin mem[a] = '0; arch[a] = '0; end

    // Reset: a pending store must not be accepted and nothing is written.
    c_req = 1'b1; c_we = 1'b1; c_addr = 10'd9; c_wdata = 32'h99;
    tick(); tick();
    #2;
    check_eq("rst_ready", 64'(c_ready), 64'd0);
    check_eq("rst_mwe", 64'(m_we), 64'd0);
    tick();
    RESET = 1'b0; c_req = 1'b0; armed = 1'b1;
    #2;
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_empty", 64'(empty), 64'd1);
    check_eq("rst_rvalid", 64'(c_rvalid), 64'd0);
    tick();

    // Test 1: streaming stores drain immediately, one entry at a time.
    max_cnt = 0; p0 = we_pulses;
    do_req(1'b1, 10'd5, 32'hA);
    do_req(1'b1, 10'd6, 32'hB);
    do_req(1'b1, 10'd7, 32'hC);
    c_req = 1'b0;
    wait_empty();
    check_eq("t1_pulses", 64'(we_pulses - p0), 64'd3);
    check_eq("t1_peak", 64'(max_cnt), 64'd1);

    // Test 2: fill, hold off the fifth store, release.
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) do_req(1'b1, AW'(i), DW'(32'h100 + i));
    c_req = 1'b1; c_we = 1'b1; c_addr = 10'd5; c_wdata = 32'h105;
    #2;
    check_eq("t2_full_ready", 64'(c_ready), 64'd0);
    check_eq("t2_full_count", 64'(count), 64'd4);
    tick();
    m_ready = 1'b1;
    #2;
    check_eq("t2_pop_ready", 64'(c_ready), 64'd0);
    check_eq("t2_pop_mwe", 64'(m_we), 64'd1);
    check_eq("t2_pop_addr", 64'(m_addr), 64'd1);
    tick();
    #2;
    check_eq("t2_accept", 64'(c_ready), 64'd1);
    tick();
    c_req = 1'b0;
    wait_empty();
    for (int i = 1; i <= 5; i++) check_eq("t2_mem", 64'(mem[i]), 64'(32'h100 + i));

    // Test 3: youngest duplicate is forwarded, no dmem access.
    m_ready = 1'b0;
    do_req(1'b1, 10'd8, 32'h11);
    do_req(1'b1, 10'd8, 32'h22);
    check_eq("t3_count", 64'(count), 64'd2);
    c_req = 1'b1; c_we = 1'b0; c_addr = 10'd8;
    #2;
    check_eq("t3_ready", 64'(c_ready), 64'd1);
    check_eq("t3_mwe", 64'(m_we), 64'd0);
    tick();
    c_req = 1'b0;
    #2;
    check_eq("t3_rvalid", 64'(c_rvalid), 64'd1);
    check_eq("t3_rdata", 64'(c_rdata), 64'h22);
    tick();
    m_ready = 1'b1;
    wait_empty();
    check_eq("t3_mem", 64'(mem[8]), 64'h22);

    // Test 4: load miss reads dmem.
    mem[20] = 32'hDEADBEEF; arch[20] = 32'hDEADBEEF;
    c_req = 1'b1; c_we = 1'b0; c_addr = 10'd20;
    #2;
    check_eq("t4_ready", 64'(c_ready), 64'd1);
    check_eq("t4_maddr", 64'(m_addr), 64'd20);
    check_eq("t4_mwe", 64'(m_we), 64'd0);
    tick();
    c_req = 1'b0;
    #2;
    check_eq("t4_rvalid", 64'(c_rvalid), 64'd1);
    check_eq("t4_rdata", 64'(c_rdata), 64'hDEADBEEF);
    tick();

    // Test 5: repeated misses starve the drain until the limit forces it.
    mem[30] = 32'h30303030; arch[30] = 32'h30303030;
    m_ready = 1'b0;
    do_req(1'b1, 10'd40, 32'h44);
    m_ready = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 10'd30;
    for (int i = 0; i < 4; i++) begin
      #2;
      check_eq("t5_miss_ready", 64'(c_ready), 64'd1);
      check_eq("t5_miss_mwe", 64'(m_we), 64'd0);
      tick();
    end
    #2;
    check_eq("t5_stall_ready", 64'(c_ready), 64'd0);
    check_eq("t5_stall_mwe", 64'(m_we), 64'd1);
    check_eq("t5_stall_addr", 64'(m_addr), 64'd40);
    tick();
    #2;
    check_eq("t5_after_ready", 64'(c_ready), 64'd1);
    check_eq("t5_after_count", 64'(count), 64'd0);
    tick();
    #2;
    check_eq("t5_sixth_ready", 64'(c_ready), 64'd1);
    tick();
    c_req = 1'b0;
    tick(); tick();
    check_eq("t5_loads_done", 64'(rq.size()), 64'd0);
    check_eq("t5_mem", 64'(mem[40]), 64'h44);

    // Test 6: reset discards buffered stores.
    m_ready = 1'b0;
    do_req(1'b1, 10'd50, 32'h50);
    do_req(1'b1, 10'd51, 32'h51);
    do_req(1'b1, 10'd52, 32'h52);
    c_req = 1'b0;
    check_eq("t6_count_pre", 64'(count), 64'd3);
    RESET = 1'b1;
    #2;
    check_eq("t6_rst_mwe", 64'(m_we), 64'd0);
    tick();
    RESET = 1'b0;
    #2;
    check_eq("t6_count", 64'(count), 64'd0);
    check_eq("t6_empty", 64'(empty), 64'd1);
    check_eq("t6_rvalid", 64'(c_rvalid), 64'd0);
    m_ready = 1'b1;
    p0 = we_pulses;
    repeat (10) tick();
    check_eq("t6_no_drain", 64'(we_pulses - p0), 64'd0);
    check_eq("t6_mem", 64'(mem[50]), 64'd0);

    // Mixed random traffic over a small address set.
    rand_mr = 1'b1;
    for (int n = 0; n < 200; n++) begin
      do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
      if ($urandom_range(0, 3) == 0) begin c_req = 1'b0; tick(); end
    end
    c_req = 1'b0;
    rand_mr = 1'b0;
    tick();
    m_ready = 1'b1;
    wait_empty();
    tick(); tick();
    check_eq("rand_loads_done", 64'(rq.size()), 64'd0);
    check_eq("rand_drains_done", 64'(wq.size()), 64'd0);
    for (int a = 0; a < 8; a++) check_eq("rand_mem", 64'(mem[a]), 64'(arch[a]));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
